// File: rtl/peripheral_msi_slave_port_qos_ahb3.sv
// AHB3-Lite slave-port arbiter: picks one master-port to own a single slave, with
// priority levels, per-level round-robin, beat quantum, starvation aging and lock.

module peripheral_msi_slave_port_qos_ahb3_lane #(
  parameter int PRIO_BITS    = 3,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 granted,
  input  logic [PRIO_BITS-1:0] prio,
  output logic                 starved,
  output logic [PRIO_BITS:0]   eff_prio
);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (!req || granted) wait_cnt <= '0;
    else if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
  end

  // an aged requester sits one level above the highest static priority
  assign starved  = (wait_cnt == LIMIT);
  assign eff_prio = starved ? {1'b1, {PRIO_BITS{1'b0}}} : {1'b0, prio};
endmodule

module peripheral_msi_slave_port_qos_ahb3 #(
  parameter int PLEN         = 64,
  parameter int XLEN         = 64,
  parameter int MASTERS      = 5,
  parameter int PRIO_BITS    = 3,
  parameter int QUANTUM      = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [MASTERS-1:0][PRIO_BITS-1:0] mstpriority,
  input  logic [MASTERS-1:0]                mstHSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]      mstHADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]      mstHWDATA,
  output logic [XLEN-1:0]                   mstHRDATA,
  input  logic [MASTERS-1:0]                mstHWRITE,
  input  logic [MASTERS-1:0][2:0]           mstHSIZE,
  input  logic [MASTERS-1:0][2:0]           mstHBURST,
  input  logic [MASTERS-1:0][3:0]           mstHPROT,
  input  logic [MASTERS-1:0][1:0]           mstHTRANS,
  input  logic [MASTERS-1:0]                mstHMASTLOCK,
  input  logic [MASTERS-1:0]                mstHREADY,
  output logic                              mstHREADYOUT,
  output logic                              mstHRESP,
  output logic                              slv_HSEL,
  output logic [PLEN-1:0]                   slv_HADDR,
  output logic [XLEN-1:0]                   slv_HWDATA,
  input  logic [XLEN-1:0]                   slv_HRDATA,
  output logic                              slv_HWRITE,
  output logic [2:0]                        slv_HSIZE,
  output logic [2:0]                        slv_HBURST,
  output logic [3:0]                        slv_HPROT,
  output logic [1:0]                        slv_HTRANS,
  output logic                              slv_HMASTLOCK,
  output logic                              slv_HREADYOUT,
  input  logic                              slv_HREADY,
  input  logic                              slv_HRESP,
  input  logic [MASTERS-1:0]                can_switch,
  output logic [MASTERS-1:0]                granted_master,
  output logic [MASTERS-1:0]                starved
);
  localparam int IDX_W  = $clog2(MASTERS);
  localparam int LVL_W  = PRIO_BITS + 1;
  localparam int LVLS   = (1 << PRIO_BITS) + 1;
  localparam int BEAT_W = $clog2(QUANTUM + 1);
  localparam logic [BEAT_W-1:0] QMAX = BEAT_W'(QUANTUM);

  logic [IDX_W-1:0]                owner, data_idx, winner, ptr;
  logic [IDX_W-1:0]                last_granted [LVLS];
  logic [BEAT_W-1:0]               beat_cnt;
  logic                            first_phase, switch_en, any_req, found;
  logic [MASTERS-1:0][LVL_W-1:0]   eff_prio;
  logic [LVL_W-1:0]                best_lvl, win_lvl;
  int                              cand;

  for (genvar m = 0; m < MASTERS; m++) begin : g_lane
    peripheral_msi_slave_port_qos_ahb3_lane #(
      .PRIO_BITS(PRIO_BITS), .STARVE_LIMIT(STARVE_LIMIT)
    ) u_lane (
      .clk(HCLK), .rst_n(HRESETn), .req(mstHSEL[m]), .granted(granted_master[m]),
      .prio(mstpriority[m]), .starved(starved[m]), .eff_prio(eff_prio[m])
    );
  end

  // highest effective level first, then round-robin after that level's pointer
  always_comb begin
    best_lvl = '0;
    any_req  = 1'b0;
    for (int m = 0; m < MASTERS; m++)
      if (mstHSEL[m] && (!any_req || eff_prio[m] > best_lvl)) begin
        best_lvl = eff_prio[m];
        any_req  = 1'b1;
      end
    ptr    = last_granted[best_lvl];
    winner = owner;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= MASTERS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= MASTERS) cand = cand - MASTERS;
      if (any_req && !found && mstHSEL[cand] && eff_prio[cand] == best_lvl) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
    win_lvl = eff_prio[winner];
  end

  assign switch_en = slv_HREADY & ~mstHMASTLOCK[owner] &
                     (can_switch[owner] | ~mstHSEL[owner] | (beat_cnt == QMAX));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner       <= '0;
      data_idx    <= '0;
      beat_cnt    <= '0;
      first_phase <= 1'b0;
      for (int l = 0; l < LVLS; l++) last_granted[l] <= '0;
    end else begin
      if (slv_HREADY) data_idx <= owner;
      if (switch_en) last_granted[win_lvl] <= winner;
      if (switch_en && winner != owner) begin
        owner       <= winner;
        beat_cnt    <= '0;
        first_phase <= 1'b1;
      end else begin
        if (slv_HREADY) first_phase <= 1'b0;
        if (slv_HREADY && slv_HTRANS[1] && beat_cnt != QMAX) beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    granted_master = '0;
    granted_master[owner] = 1'b1;
  end

  // a SEQ right after a grant change continues nothing the slave has seen
  assign slv_HTRANS    = (first_phase && mstHTRANS[owner] == 2'b11) ? 2'b10 : mstHTRANS[owner];
  assign slv_HSEL      = mstHSEL[owner];
  assign slv_HADDR     = mstHADDR[owner];
  assign slv_HWRITE    = mstHWRITE[owner];
  assign slv_HSIZE     = mstHSIZE[owner];
  assign slv_HBURST    = mstHBURST[owner];
  assign slv_HPROT     = mstHPROT[owner];
  assign slv_HMASTLOCK = mstHMASTLOCK[owner];
  assign slv_HREADYOUT = mstHREADY[owner];
  assign slv_HWDATA    = mstHWDATA[data_idx];
  assign mstHRDATA     = slv_HRDATA;
  assign mstHREADYOUT  = slv_HREADY;
  assign mstHRESP      = slv_HRESP;
endmodule
